// File: rtl/mul2a_4_pkg.sv
// Shared widths and the 2x2 kernel width for the 4x4 approximate multiplier.
package mul2a_4_pkg;

    localparam int OP_W   = 4;
    localparam int HALF_W = 2;
    localparam int KER_W  = 3;
    localparam int PROD_W = 8;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [HALF_W-1:0] half_t;
    typedef logic [KER_W-1:0]  ker_t;
    typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mul2a_4_if.sv
// Operand/result bundle between the multiplier and its producer/consumer.
interface mul2a_4_if;
    import mul2a_4_pkg::*;

    logic  in_valid;
    op_t   a;
    op_t   b;
    prod_t Y;
    logic  out_valid;

    modport master (output in_valid, a, b, input  Y, out_valid);
    modport slave  (input  in_valid, a, b, output Y, out_valid);

endinterface

// File: rtl/mul2a_2x2.sv
// 2x2 approximate multiplier kernel: exact except 3x3, which yields 7 to fit 3 bits.
module mul2a_2x2
    import mul2a_4_pkg::*;
(
    input  half_t x,
    input  half_t y,
    output ker_t  p
);

    ker_t exact;

    assign exact = {1'b0, x} * {1'b0, y};
    assign p     = (x == 2'd3 && y == 2'd3) ? 3'd7 : exact;

endmodule

// File: rtl/mul2a_4.sv
// 4x4 approximate unsigned multiplier built from four 2x2 kernels, one-cycle registered result.
module mul2a_4
    import mul2a_4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mul2a_4_if.slave   bus
);

    half_t a_h, a_l, b_h, b_l;
    ker_t  p_hh, p_hl, p_lh, p_ll;
    prod_t sum;

    assign a_h = bus.a[OP_W-1:HALF_W];
    assign a_l = bus.a[HALF_W-1:0];
    assign b_h = bus.b[OP_W-1:HALF_W];
    assign b_l = bus.b[HALF_W-1:0];

    mul2a_2x2 u_hh (.x(a_h), .y(b_h), .p(p_hh));
    mul2a_2x2 u_hl (.x(a_h), .y(b_l), .p(p_hl));
    mul2a_2x2 u_lh (.x(a_l), .y(b_h), .p(p_lh));
    mul2a_2x2 u_ll (.x(a_l), .y(b_l), .p(p_ll));

    // Widen every term before adding so the cross-term sum keeps its carry.
    assign sum = (prod_t'(p_hh) << 4)
               + ((prod_t'(p_hl) + prod_t'(p_lh)) << 2)
               + prod_t'(p_ll);

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Y         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.Y <= sum;
            end
        end
    end

endmodule

// File: tb/tb_mul2a_4.sv
// Scoreboard bench for mul2a_4: directed vectors, exhaustive sweep, latency, streaming, reset.
module tb_mul2a_4;

    logic clk;
    logic rst_n;

    mul2a_4_if bus ();

    mul2a_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int  id;
        int  a;
        int  b;
        int  y;
        bit  sweep;
    } exp_t;

    exp_t sb[$];
    int   n_cmp      = 0;
    int   n_fail     = 0;
    int   exact_hits = 0;
    int   next_id    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int kern(input int x, input int y);
        return (x == 3 && y == 3) ? 7 : x * y;
    endfunction

    function automatic int model(input int a, input int b);
        int ah, al, bh, bl;
        ah = a / 4; al = a % 4; bh = b / 4; bl = b % 4;
        return kern(ah, bh) * 16 + (kern(ah, bl) + kern(al, bh)) * 4 + kern(al, bl);
    endfunction

    task automatic send(input int a, input int b, input int y_exp, input bit sweep);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 4'(a);
        bus.b        = 4'(b);
        e.id = next_id; e.a = a; e.b = b; e.y = y_exp; e.sweep = sweep;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got Y=%0d, expected no result", bus.Y);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("sb#%0d a=%0d b=%0d", e.id, e.a, e.b), int'(bus.Y), e.y);
                if (e.sweep && int'(bus.Y) == e.a * e.b) exact_hits++;
            end
        end
    end

    initial begin
        int a_tab [6] = '{3, 15, 13, 12, 15, 0};
        int b_tab [6] = '{3, 15,  7, 12,  1, 15};
        int y_tab [6] = '{7, 175, 83, 112, 15, 0};
        int waited;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        #3;
        check("reset_Y", int'(bus.Y), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed pairs with hand-computed results.
        for (int i = 0; i < 6; i++) send(a_tab[i], b_tab[i], y_tab[i], 1'b0);
        idle();

        // Latency and hold.
        send(5, 6, 30, 1'b0);
        @(posedge clk); #1;
        check("latency_Y", int'(bus.Y), 30);
        check("latency_out_valid", int'(bus.out_valid), 1);
        idle();
        @(posedge clk); #1;
        check("hold_Y", int'(bus.Y), 30);
        check("hold_out_valid", int'(bus.out_valid), 0);

        // Streaming back-to-back results.
        send(2, 3, 6, 1'b0);
        send(3, 3, 7, 1'b0);
        send(15, 15, 175, 1'b0);
        idle();
        @(posedge clk); #2;
        check("pre_reset_Y", int'(bus.Y), 175);

        // Asynchronous reset between edges.
        rst_n = 1'b0;
        #1;
        check("async_reset_Y", int'(bus.Y), 0);
        check("async_reset_out_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle_out_valid", int'(bus.out_valid), 0);

        // First valid after reset release.
        send(9, 10, 90, 1'b0);
        @(posedge clk); #1;
        check("first_after_reset_out_valid", int'(bus.out_valid), 1);
        check("first_after_reset_Y", int'(bus.Y), 90);

        // Exhaustive sweep against the split-kernel model.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                send(a, b, model(a, b), 1'b1);
        idle();

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", sb.size(), 0);
        check("sweep_exact_count", exact_hits, 207);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
